layer_output_serializer: RTL and testbench
==========================================

Name: layer_output_serializer

Overview:
- Sits directly downstream of a layer of positron engines (4-bit posit, es=0).
- Each positron emits one sigmoid-activated posit per window, with rts and eow asserted together.
- This block collects one result from each of NB_POSITRON engines into a slot buffer, then serializes them as one window (sow … eow) on a single posit stream.
- The output stream feeds the next layer's positron inputs.

Parameters:
- POSIT_WIDTH, 4, width of one posit word.
- NB_POSITRON, 16, number of upstream positrons (= output window length); must be ≥ 2.
- IDX_WIDTH, log2(NB_POSITRON) (minimum 1), width of the slot/emit index; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- rts_i  in  NB_POSITRON  per-positron ready-to-send.
- eow_i  in  NB_POSITRON  per-positron end-of-window.
- posit_i  in  NB_POSITRON*POSIT_WIDTH  per-positron posit; slot k occupies bits [k*POSIT_WIDTH +: POSIT_WIDTH].
- rtr_o  out  NB_POSITRON  per-positron ready-to-receive; drives positron k's rtr_i.
- rtr_i  in  1  downstream ready-to-receive.
- rts_o  out  1  output word valid.
- sow_o  out  1  start of output window (qualified by rts_o).
- eow_o  out  1  end of output window (qualified by rts_o).
- posit_o  out  POSIT_WIDTH  serialized posit.

Behaviour:
- Reset (async, rst_n=0): state=COLLECT, all slot-valid flags=0, emit index=0, slot data=0.
  - Outputs during reset: rts_o=0, sow_o=0, eow_o=0, posit_o=0.
  - rtr_o = all ones, combinational from state after reset.
  - Reset asserted mid-COLLECT or mid-EMIT discards all captured data; no partial window is ever emitted after reset.
- State COLLECT:
  - rtr_o[k] = ~valid[k].
  - Capture on posedge when rts_i[k] & eow_i[k] & rtr_o[k]: slot[k] <= posit_i[k], valid[k] <= 1.
  - rts_i[k] without eow_i[k] is ignored; no capture, no error.
  - Any number of slots may capture in the same cycle.
  - A filled slot stays rtr_o[k]=0, backpressuring that positron's quire until the window is emitted.
  - Transition to EMIT on the clock edge where all valid bits become or remain 1 (valid_next == all ones). Emit index <= 0.
- State EMIT:
  - rtr_o = all zeros; no capture.
  - rts_o=1; posit_o=slot[idx].
  - sow_o=(idx==0); eow_o=(idx==NB_POSITRON-1).
  - Handshake on rts_o & rtr_i: idx <= idx+1.
  - If rtr_i=0, posit_o, sow_o, eow_o and idx hold stable.
  - On the handshake with idx==NB_POSITRON-1: all valid <= 0, idx <= 0, state <= COLLECT. rtr_o returns to all ones the following cycle.
- Latency:
  - Last slot capture at edge N → first output word (rts_o=1, sow_o=1) visible in the cycle after edge N.
  - With rtr_i held high, the window drains in exactly NB_POSITRON cycles.
  - Minimum period per window = 1 + NB_POSITRON cycles.
- Outputs rts_o, sow_o, eow_o and posit_o are registered-state-derived only; no combinational path from rtr_i or any slave input to them.
- sow_o and eow_o are never both 1, since NB_POSITRON ≥ 2.
- rtr_o depends only on state and valid flags; no combinational path from rts_i.
- Slot order on the output is the index order 0..NB_POSITRON-1, independent of arrival order.
- No NaR handling; posit words pass bit-exact.

Test Plan (NB_POSITRON=4, POSIT_WIDTH=4):
- Basic window:
  - Stimulus: in one cycle assert rts_i=4'b1111, eow_i=4'b1111, posits {3,2,1,0} = {4'h7,4'h4,4'hC,4'h1}; hold rtr_i=1.
  - Response: next cycle through +3, posit_o = 1, C, 4, 7 with rts_o=1; sow_o only on the first word, eow_o only on the fourth.
  - Then rts_o=0 and rtr_o=4'b1111.
- Staggered arrival:
  - Stimulus: slots 2, 0, 3, 1 arrive on consecutive cycles.
  - Response: rtr_o drops per slot (4'b1011, then 4'b1010, then 4'b0010); no output until the cycle after slot 1 captures.
  - Output is still emitted in index order 0..3.
- Backpressure:
  - Stimulus: during EMIT, rtr_i=0 for 3 cycles at idx=2.
  - Response: posit_o=slot[2], eow_o=0 and rts_o=1 stay stable for those 3 cycles; the window completes with exactly 4 handshakes.
- Qualification:
  - Stimulus: rts_i[1]=1 with eow_i[1]=0.
  - Response: no capture, rtr_o[1] stays 1.
  - Stimulus: a second result on slot 0 while valid[0]=1.
  - Response: it is not accepted (rtr_o[0]=0) and the slot value is unchanged.
- Reset mid-window:
  - Stimulus: assert rst_n=0 at idx=1 during EMIT.
  - Response: rts_o=0 and rtr_o=4'b1111 immediately.
  - After release, a fresh 4-slot collection emits only the new values.
- Back-to-back windows:
  - Stimulus: upstream positrons hold rts_i=4'b1111 and eow_i=4'b1111 continuously.
  - Response: windows repeat every 5 cycles.

Source files
------------

// File: rtl/layer_output_serializer.sv
// Layer output serializer: gathers one sigmoid-activated posit from each
// upstream positron into a slot buffer, then streams the full set as one
// window (sow ... eow) in slot-index order to the next layer.
module layer_output_serializer #(
  parameter int POSIT_WIDTH = 4,
  parameter int NB_POSITRON = 16
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NB_POSITRON-1:0]             rts_i,
  input  logic [NB_POSITRON-1:0]             eow_i,
  input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
  output logic [NB_POSITRON-1:0]             rtr_o,
  input  logic                               rtr_i,
  output logic                               rts_o,
  output logic                               sow_o,
  output logic                               eow_o,
  output logic [POSIT_WIDTH-1:0]             posit_o
);

  localparam int IDX_WIDTH = (NB_POSITRON <= 2) ? 1 : $clog2(NB_POSITRON);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NB_POSITRON - 1);
  localparam logic [NB_POSITRON-1:0] ALL_ONES = {NB_POSITRON{1'b1}};
  localparam logic [NB_POSITRON-1:0] ALL_ZEROS = {NB_POSITRON{1'b0}};

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } state_t;

  state_t                               state_r;
  logic [NB_POSITRON-1:0]               valid_r;
  logic [NB_POSITRON*POSIT_WIDTH-1:0]   slot_r;
  logic [IDX_WIDTH-1:0]                 idx_r;
  logic                                 rts_r;
  logic                                 sow_r;
  logic                                 eow_r;
  logic [POSIT_WIDTH-1:0]               posit_r;

  logic [NB_POSITRON-1:0]               cap_s;
  logic [NB_POSITRON-1:0]               valid_next_s;
  logic [NB_POSITRON*POSIT_WIDTH-1:0]   slot_next_s;
  logic [IDX_WIDTH-1:0]                 idx_inc_s;

  // Select one posit word out of a packed slot buffer.
  function automatic logic [POSIT_WIDTH-1:0] get_slot(
    input logic [NB_POSITRON*POSIT_WIDTH-1:0] buf_v,
    input logic [IDX_WIDTH-1:0]               sel
  );
    return buf_v[sel*POSIT_WIDTH +: POSIT_WIDTH];
  endfunction

  // Ready-to-receive per positron: open only for empty slots while collecting.
  always_comb begin
    rtr_o = ALL_ZEROS;
    if (state_r == COLLECT) begin
      rtr_o = ~valid_r;
    end else begin
      rtr_o = ALL_ZEROS;
    end
  end

  // Capture qualification: a result is taken only with eow and an empty slot.
  always_comb begin
    cap_s = ALL_ZEROS;
    if (state_r == COLLECT) begin
      cap_s = rts_i & eow_i & ~valid_r;
    end else begin
      cap_s = ALL_ZEROS;
    end
    valid_next_s = valid_r | cap_s;
    idx_inc_s    = idx_r + IDX_WIDTH'(1);
  end

  // Next slot contents, merging this cycle's captures over the held values.
  always_comb begin
    slot_next_s = slot_r;
    for (int k = 0; k < NB_POSITRON; k++) begin
      if (cap_s[k]) begin
        slot_next_s[k*POSIT_WIDTH +: POSIT_WIDTH] = posit_i[k*POSIT_WIDTH +: POSIT_WIDTH];
      end else begin
        slot_next_s[k*POSIT_WIDTH +: POSIT_WIDTH] = slot_r[k*POSIT_WIDTH +: POSIT_WIDTH];
      end
    end
  end

  // Collect/emit FSM; output word, sow and eow are loaded one step ahead so
  // they come straight from flops and never see rtr_i combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= COLLECT;
      valid_r <= ALL_ZEROS;
      slot_r  <= {(NB_POSITRON*POSIT_WIDTH){1'b0}};
      idx_r   <= {IDX_WIDTH{1'b0}};
      rts_r   <= 1'b0;
      sow_r   <= 1'b0;
      eow_r   <= 1'b0;
      posit_r <= {POSIT_WIDTH{1'b0}};
    end else begin
      case (state_r)
        COLLECT: begin
          slot_r  <= slot_next_s;
          valid_r <= valid_next_s;
          idx_r   <= {IDX_WIDTH{1'b0}};
          if (valid_next_s == ALL_ONES) begin
            state_r <= EMIT;
            rts_r   <= 1'b1;
            sow_r   <= 1'b1;
            eow_r   <= 1'b0;
            posit_r <= get_slot(slot_next_s, {IDX_WIDTH{1'b0}});
          end else begin
            state_r <= COLLECT;
            rts_r   <= 1'b0;
            sow_r   <= 1'b0;
            eow_r   <= 1'b0;
            posit_r <= {POSIT_WIDTH{1'b0}};
          end
        end
        EMIT: begin
          if (rtr_i) begin
            if (idx_r == LAST_IDX) begin
              state_r <= COLLECT;
              valid_r <= ALL_ZEROS;
              idx_r   <= {IDX_WIDTH{1'b0}};
              rts_r   <= 1'b0;
              sow_r   <= 1'b0;
              eow_r   <= 1'b0;
              posit_r <= {POSIT_WIDTH{1'b0}};
            end else begin
              idx_r   <= idx_inc_s;
              sow_r   <= 1'b0;
              eow_r   <= (idx_inc_s == LAST_IDX);
              posit_r <= get_slot(slot_r, idx_inc_s);
            end
          end else begin
            idx_r   <= idx_r;
            posit_r <= posit_r;
          end
        end
        default: begin
          state_r <= COLLECT;
          valid_r <= ALL_ZEROS;
          idx_r   <= {IDX_WIDTH{1'b0}};
          rts_r   <= 1'b0;
          sow_r   <= 1'b0;
          eow_r   <= 1'b0;
          posit_r <= {POSIT_WIDTH{1'b0}};
        end
      endcase
    end
  end

  assign rts_o   = rts_r;
  assign sow_o   = sow_r;
  assign eow_o   = eow_r;
  assign posit_o = posit_r;

endmodule

// File: tb/tb_layer_output_serializer.sv
// Directed bench for layer_output_serializer with 4 positrons of 4-bit posits.
module tb_layer_output_serializer;

  localparam int W = 4;
  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   rts_i;
  logic [N-1:0]   eow_i;
  logic [N*W-1:0] posit_i;
  logic [N-1:0]   rtr_o;
  logic           rtr_i;
  logic           rts_o;
  logic           sow_o;
  logic           eow_o;
  logic [W-1:0]   posit_o;

  int total;
  int bad;

  layer_output_serializer #(.POSIT_WIDTH(W), .NB_POSITRON(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .rts_i   (rts_i),
    .eow_i   (eow_i),
    .posit_i (posit_i),
    .rtr_o   (rtr_o),
    .rtr_i   (rtr_i),
    .rts_o   (rts_o),
    .sow_o   (sow_o),
    .eow_o   (eow_o),
    .posit_o (posit_o)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one output word at window position pos.
  task automatic expect_word(input string tag, input int pos, input logic [W-1:0] p);
    chk({tag, "_rts"}, {31'd0, rts_o}, 32'd1);
    chk({tag, "_sow"}, {31'd0, sow_o}, (pos == 0) ? 32'd1 : 32'd0);
    chk({tag, "_eow"}, {31'd0, eow_o}, (pos == N - 1) ? 32'd1 : 32'd0);
    chk({tag, "_posit"}, {28'd0, posit_o}, {28'd0, p});
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    rts_i   = 4'b0000;
    eow_i   = 4'b0000;
    posit_i = 16'h0000;
    rtr_i   = 1'b1;
    #1;
    // Reset state
    chk("rst_rts", {31'd0, rts_o}, 32'd0);
    chk("rst_sow", {31'd0, sow_o}, 32'd0);
    chk("rst_eow", {31'd0, eow_o}, 32'd0);
    chk("rst_posit", {28'd0, posit_o}, 32'd0);
    chk("rst_rtr", {28'd0, rtr_o}, 32'hF);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Basic window: all four results in one cycle
    rts_i   = 4'b1111;
    eow_i   = 4'b1111;
    posit_i = {4'h7, 4'h4, 4'hC, 4'h1};
    tick();
    rts_i = 4'b0000;
    eow_i = 4'b0000;
    chk("basic_rtr_emit", {28'd0, rtr_o}, 32'h0);
    expect_word("basic_w0", 0, 4'h1);
    tick();
    expect_word("basic_w1", 1, 4'hC);
    tick();
    expect_word("basic_w2", 2, 4'h4);
    tick();
    expect_word("basic_w3", 3, 4'h7);
    tick();
    chk("basic_done_rts", {31'd0, rts_o}, 32'd0);
    chk("basic_done_rtr", {28'd0, rtr_o}, 32'hF);

    // Staggered arrival: slots 2, 0, 3, 1 (other lanes carry junk)
    rts_i   = 4'b0100;
    eow_i   = 4'b0100;
    posit_i = {4'hF, 4'h5, 4'hF, 4'hF};
    tick();
    chk("stag_rtr_a", {28'd0, rtr_o}, 32'hB);
    chk("stag_rts_a", {31'd0, rts_o}, 32'd0);
    rts_i   = 4'b0001;
    eow_i   = 4'b0001;
    posit_i = {4'hF, 4'hF, 4'hF, 4'hA};
    tick();
    chk("stag_rtr_b", {28'd0, rtr_o}, 32'hA);
    chk("stag_rts_b", {31'd0, rts_o}, 32'd0);
    rts_i   = 4'b1000;
    eow_i   = 4'b1000;
    posit_i = {4'hE, 4'hF, 4'hF, 4'hF};
    tick();
    chk("stag_rtr_c", {28'd0, rtr_o}, 32'h2);
    chk("stag_rts_c", {31'd0, rts_o}, 32'd0);
    rts_i   = 4'b0010;
    eow_i   = 4'b0010;
    posit_i = {4'hF, 4'hF, 4'h3, 4'hF};
    tick();
    rts_i = 4'b0000;
    eow_i = 4'b0000;
    expect_word("stag_w0", 0, 4'hA);
    tick();
    expect_word("stag_w1", 1, 4'h3);
    tick();
    // Backpressure at idx=2 for three cycles
    rtr_i = 1'b0;
    expect_word("bp_w2", 2, 4'h5);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_word("bp_hold", 2, 4'h5);
    end
    rtr_i = 1'b1;
    tick();
    expect_word("bp_w3", 3, 4'hE);
    tick();
    chk("bp_done_rts", {31'd0, rts_o}, 32'd0);
    chk("bp_done_rtr", {28'd0, rtr_o}, 32'hF);

    // Qualification: rts without eow is ignored
    rts_i   = 4'b0010;
    eow_i   = 4'b0000;
    posit_i = {4'h0, 4'h0, 4'h9, 4'h0};
    tick();
    chk("qual_noeow_rtr", {28'd0, rtr_o}, 32'hF);
    rts_i   = 4'b0001;
    eow_i   = 4'b0001;
    posit_i = {4'h0, 4'h0, 4'h0, 4'h2};
    tick();
    chk("qual_fill0_rtr", {28'd0, rtr_o}, 32'hE);
    // Second result for slot 0 must be refused
    posit_i = {4'h0, 4'h0, 4'h0, 4'hB};
    tick();
    chk("qual_refuse_rtr", {28'd0, rtr_o}, 32'hE);
    chk("qual_refuse_rts", {31'd0, rts_o}, 32'd0);
    rts_i   = 4'b1110;
    eow_i   = 4'b1110;
    posit_i = {4'hD, 4'h8, 4'h6, 4'hB};
    tick();
    rts_i = 4'b0000;
    eow_i = 4'b0000;
    expect_word("qual_w0", 0, 4'h2);
    tick();
    expect_word("qual_w1", 1, 4'h6);
    tick();
    expect_word("qual_w2", 2, 4'h8);
    tick();
    expect_word("qual_w3", 3, 4'hD);
    tick();
    chk("qual_done_rts", {31'd0, rts_o}, 32'd0);

    // Reset in the middle of EMIT at idx=1
    rts_i   = 4'b1111;
    eow_i   = 4'b1111;
    posit_i = {4'h4, 4'h3, 4'h2, 4'h1};
    tick();
    rts_i = 4'b0000;
    eow_i = 4'b0000;
    expect_word("mrst_w0", 0, 4'h1);
    tick();
    expect_word("mrst_w1", 1, 4'h2);
    rst_n = 1'b0;
    #1;
    chk("mrst_rts", {31'd0, rts_o}, 32'd0);
    chk("mrst_rtr", {28'd0, rtr_o}, 32'hF);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_after_rts", {31'd0, rts_o}, 32'd0);
    chk("mrst_after_rtr", {28'd0, rtr_o}, 32'hF);
    rts_i   = 4'b1111;
    eow_i   = 4'b1111;
    posit_i = {4'h5, 4'h6, 4'h8, 4'h9};
    tick();
    rts_i = 4'b0000;
    eow_i = 4'b0000;
    expect_word("fresh_w0", 0, 4'h9);
    tick();
    expect_word("fresh_w1", 1, 4'h8);
    tick();
    expect_word("fresh_w2", 2, 4'h6);
    tick();
    expect_word("fresh_w3", 3, 4'h5);
    tick();
    chk("fresh_done_rts", {31'd0, rts_o}, 32'd0);

    // Back-to-back windows: upstream always offering, period of 5 cycles
    rts_i   = 4'b1111;
    eow_i   = 4'b1111;
    posit_i = {4'hC, 4'hD, 4'hE, 4'hF};
    tick();
    for (int w = 0; w < 3; w++) begin
      expect_word("b2b_w0", 0, 4'hF);
      tick();
      expect_word("b2b_w1", 1, 4'hE);
      tick();
      expect_word("b2b_w2", 2, 4'hD);
      tick();
      expect_word("b2b_w3", 3, 4'hC);
      tick();
      chk("b2b_gap_rts", {31'd0, rts_o}, 32'd0);
      chk("b2b_gap_rtr", {28'd0, rtr_o}, 32'hF);
      tick();
    end
    rts_i = 4'b0000;
    eow_i = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
